midi_transmitter: RTL

- Serial MIDI transmitter. It is the output-side counterpart of the team's MIDI receiver.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte as a standard MIDI frame on midi_out: 8N1, LSB first, idle high, 1 start bit, 8 data bits, 1 stop bit.
- Bit timing uses the same CLKS_PER_BIT tick count as the receiver, so the two loop back directly.

---
 rtl/midi_transmitter_if.sv | 10 +
 rtl/midi_transmitter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/midi_transmitter_if.sv
// Byte-stream handshake between a MIDI byte producer and the transmitter.
// The master drives bytes and the slave (the transmitter) signals free FIFO space.
interface midi_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/midi_transmitter.sv
// Serial MIDI transmitter: byte FIFO feeding an 8N1 LSB-first serialiser on midi_out.
// Define MIDI_RUNNING_STATUS_EN to drop repeated channel status bytes (running status).
module midi_transmitter #(
    parameter int CLKS_PER_BIT = 128,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    midi_transmitter_if.slave             tx_if,
    output logic                          midi_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [TW-1:0]  tick;
    logic [TW-1:0]  tick_next;
    logic [2:0]     bit_idx;
    logic [2:0]     bit_idx_next;
    logic [7:0]     shifter;
    logic [7:0]     shifter_next;
    logic [7:0]     head;
    logic           push;
    logic           pop;
    logic           line_next;
    logic           drop_head;

    assign tx_if.tx_ready = (count != DEPTH_C);
    assign push           = tx_if.tx_valid && tx_if.tx_ready;
    assign head           = mem[rd_ptr];
    assign busy           = (state != IDLE) || (count != '0);
    assign fifo_count     = count;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic [7:0] last_status_next;

    // Channel status repeating the previous one is redundant on the wire.
    always_comb begin
        drop_head        = 1'b0;
        last_status_next = last_status;
        if (head >= 8'h80 && head <= 8'hEF) begin
            if (head == last_status) begin
                drop_head = 1'b1;
            end else begin
                last_status_next = head;
            end
        end else if (head >= 8'hF0 && head <= 8'hF7) begin
            last_status_next = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_status <= 8'h00;
        end else if (pop) begin
            last_status <= last_status_next;
        end
    end
`else
    assign drop_head = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_if.tx_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        tick_next    = tick;
        bit_idx_next = bit_idx;
        shifter_next = shifter;
        pop          = 1'b0;
        line_next    = 1'b1;
        case (state)
            IDLE: begin
                tick_next    = '0;
                bit_idx_next = '0;
                if (count != '0) begin
                    pop = 1'b1;
                    if (!drop_head) begin
                        shifter_next = head;
                        state_next   = START;
                    end
                end
            end
            START: begin
                line_next = 1'b0;
                if (tick == TICK_MAX) begin
                    tick_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            DATA: begin
                line_next = shifter[0];
                if (tick == TICK_MAX) begin
                    tick_next    = '0;
                    shifter_next = {1'b0, shifter[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            STOP: begin
                if (tick == TICK_MAX) begin
                    tick_next  = '0;
                    state_next = IDLE;
                    // Chain straight into the next start bit so frames abut.
                    if (count != '0) begin
                        pop = 1'b1;
                        if (!drop_head) begin
                            shifter_next = head;
                            state_next   = START;
                        end
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // midi_out is registered, so the wire trails the FSM state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            midi_out <= 1'b1;
        end else begin
            state    <= state_next;
            tick     <= tick_next;
            bit_idx  <= bit_idx_next;
            shifter  <= shifter_next;
            midi_out <= line_next;
        end
    end

endmodule
